axi_lite_slave_mem: RTL and testbench
=====================================

AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 awvalid  input  1  write address valid.
REQ-006 awaddr  input  32  write byte address.
REQ-007 awprot  input  3  ignored.
REQ-008 awready  output  1  write address accepted.
REQ-009 wvalid  input  1  write data valid.
REQ-010 wdata  input  32  write data.
REQ-011 wstrb  input  4  byte enables; bit i gates wdata[8i+7:8i].
REQ-012 wready  output  1  write data accepted.
REQ-013 bvalid  output  1  write response valid.
REQ-014 bresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-015 bready  input  1  master accepts response.
REQ-016 arvalid  input  1  read address valid.
REQ-017 araddr  input  32  read byte address.
REQ-018 arprot  input  3  ignored.
REQ-019 arready  output  1  read address accepted.
REQ-020 rvalid  output  1  read data valid.
REQ-021 rdata  output  32  read data.
REQ-022 rresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-023 rlast  output  1  equals rvalid (single-beat).
REQ-024 rready  input  1  master accepts read data.

Function
REQ-025 Handshake on a channel = valid & ready high at the same rising edge; outputs registered, no combinational path input->output.
REQ-026 Write FSM states WR_IDLE, WR_RESP; read FSM states RD_IDLE, RD_DATA; the two FSMs are independent and may be active in the same cycle.
REQ-027 WR_IDLE: awready=1 while no AW latched, wready=1 while no W latched; AW and W accepted in either order or together; a latched channel holds its ready low.
REQ-028 Edge at which both AW and W are held (latched earlier or handshaking now): memory write commits, FSM -> WR_RESP, bvalid=1 from next cycle (1-cycle latency when both arrive together).
REQ-029 WR_RESP: awready=wready=0; bvalid, bresp held stable until bvalid&bready, then -> WR_IDLE with awready=wready=1 next cycle.
REQ-030 RD_IDLE: arready=1, rvalid=0; on AR handshake memory read at that edge, -> RD_DATA, rvalid=1 next cycle (1-cycle latency).
REQ-031 RD_DATA: arready=0; rdata, rresp, rlast held stable until rvalid&rready, then -> RD_IDLE.
REQ-032 Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored; in range iff BASE_ADDR <= addr and addr - BASE_ADDR < DEPTH_WORDS*4, unsigned 32-bit compare, no wrap.
REQ-033 Out-of-range write: no memory change, bresp=2'b10; out-of-range read: rdata=32'h0, rresp=2'b10.
REQ-034 Write updates only bytes with wstrb bit set; wstrb=4'b0000 in range -> no change, bresp OKAY.
REQ-035 Same-edge AR handshake and write commit to same word: read returns pre-write data.
REQ-036 Back-to-back: new AR accepted only after previous R handshake (max one outstanding per direction); minimum throughput one transaction per 2 cycles per channel.

Reset
REQ-037 reset=1 at an edge: both FSMs -> IDLE, latched AW/W discarded, bvalid=rvalid=rlast=0, bresp=rresp=2'b00, rdata=32'h0, awready=wready=arready=0 while reset held, =1 first cycle after release.
REQ-038 Reset mid-transaction aborts it; a pending uncommitted write never reaches memory; memory contents are not cleared by reset.

Verification
REQ-039 AW+W together, addr=BASE+0x10, wdata=32'hDEADBEEF, wstrb=4'hF, bready=1 -> bvalid next cycle, bresp=00; read 0x10 -> rdata=32'hDEADBEEF, rresp=00, rlast=1.
REQ-040 W 3 cycles before AW, wstrb=4'b0101, wdata=32'h11223344 over 32'hAAAAAAAA -> wready low after W handshake, bvalid 1 cycle after AW, read -> 32'hAA22AA44.
REQ-041 Read addr=BASE+DEPTH_WORDS*4 and write same address -> rresp=10, rdata=0, bresp=10, memory unchanged.
REQ-042 bready, rready low 5 cycles -> bvalid, rvalid, rdata, bresp stable all 5 cycles; awready/arready stay 0 until handshake.
REQ-043 Same-edge commit of 32'h0 and AR to word holding 32'h5 -> rdata=32'h5; subsequent read -> 32'h0.
REQ-044 reset asserted cycle after AW-only handshake, W then sent post-reset without AW -> no bvalid, memory unchanged; all outputs at REQ-037 values.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// axi_lite_slave_mem: AXI4-Lite slave backed by a word-addressed memory with byte strobes
module axi_lite_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  input  logic        bready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  input  logic        rready
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
  wr_state_e wr_q, wr_d;
  rd_state_e rd_q, rd_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic aw_hs, w_hs, ar_hs, mem_we, wr_ok, rd_ok;
  logic [31:0] wr_addr, wr_data;
  logic [3:0] wr_strb;
  logic [32:0] wr_diff, rd_diff;
  logic unused_prot;
  assign aw_hs = awvalid & awready_q;
  assign w_hs = wvalid & wready_q;
  assign ar_hs = arvalid & arready_q;
  // A channel handshaking this edge takes priority over its latched copy
  assign wr_addr = aw_hs ? awaddr : awaddr_q;
  assign wr_data = w_hs ? wdata : wdata_q;
  assign wr_strb = w_hs ? wstrb : wstrb_q;
  // 33-bit difference: bit 32 flags an address below the base without wrapping
  assign wr_diff = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
  assign rd_diff = {1'b0, araddr} - {1'b0, BASE_ADDR};
  assign wr_ok = !wr_diff[32] && wr_diff[31:0] < SPAN;
  assign rd_ok = !rd_diff[32] && rd_diff[31:0] < SPAN;
  assign unused_prot = ^{awprot, arprot};
  assign awready = awready_q;
  assign wready = wready_q;
  assign arready = arready_q;
  assign bvalid = bvalid_q;
  assign bresp = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rlast = rvalid_q;
  // Write FSM: collect AW and W in any order, commit once both are held
  always_comb begin
    wr_d = wr_q;
    aw_held_d = aw_held_q | aw_hs;
    w_held_d = w_held_q | w_hs;
    awaddr_d = wr_addr;
    wdata_d = wr_data;
    wstrb_d = wr_strb;
    bvalid_d = bvalid_q;
    bresp_d = bresp_q;
    mem_we = 1'b0;
    if (wr_q == WR_IDLE && aw_held_d && w_held_d) begin
      wr_d = WR_RESP;
      aw_held_d = 1'b0;
      w_held_d = 1'b0;
      bvalid_d = 1'b1;
      bresp_d = wr_ok ? 2'b00 : 2'b10;
      mem_we = wr_ok;
    end else if (wr_q == WR_RESP && bready) begin
      wr_d = WR_IDLE;
      bvalid_d = 1'b0;
    end
    awready_d = wr_d == WR_IDLE && !aw_held_d;
    wready_d = wr_d == WR_IDLE && !w_held_d;
  end
  // Read FSM: sample memory at the AR edge so a same-edge write is not visible
  always_comb begin
    rd_d = rd_q;
    rvalid_d = rvalid_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rd_d = RD_DATA;
      rvalid_d = 1'b1;
      rdata_d = rd_ok ? mem[rd_diff[AW+1:2]] : 32'h0;
      rresp_d = rd_ok ? 2'b00 : 2'b10;
    end else if (rd_q == RD_DATA && rready) begin
      rd_d = RD_IDLE;
      rvalid_d = 1'b0;
    end
    arready_d = rd_d == RD_IDLE;
  end
  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= WR_IDLE;
      rd_q <= RD_IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      awaddr_q <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      rvalid_q <= 1'b0;
      rdata_q <= 32'h0;
      rresp_q <= 2'b00;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      arready_q <= arready_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end
  // Memory array survives reset; only strobed bytes are written
  always_ff @(posedge clk) begin
    if (mem_we && !reset)
      for (int i = 0; i < 4; i++)
        if (wr_strb[i]) mem[wr_diff[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
  end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb_axi_lite_slave_mem: directed self-checking bench for axi_lite_slave_mem
module tb_axi_lite_slave_mem;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 1'b0, reset = 1'b1;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [3:0] wstrb = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int cmp = 0, err = 0;
  axi_lite_slave_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp, output int lat);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 0;
    tick;
    awvalid = 0; wvalid = 0;
    lat = 0;
    while (!bvalid && lat < 10) begin tick; lat++; end
    resp = bresp; bready = 1;
    tick;
    bready = 0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output logic last, output int lat);
    arvalid = 1; araddr = a; rready = 0;
    tick;
    arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 10) begin tick; lat++; end
    d = rdata; resp = rresp; last = rlast; rready = 1;
    tick;
    rready = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    tick; tick;
    cmp++; if ({awready, wready, arready} !== 3'b000) begin err++; $display("FAIL rst_ready: got %b expected 000", {awready, wready, arready}); end
    cmp++; if ({bvalid, rvalid, rlast} !== 3'b000) begin err++; $display("FAIL rst_valid: got %b expected 000", {bvalid, rvalid, rlast}); end
    cmp++; if ({bresp, rresp} !== 4'b0000) begin err++; $display("FAIL rst_resp: got %b expected 0000", {bresp, rresp}); end
    cmp++; if (rdata !== 32'h0) begin err++; $display("FAIL rst_rdata: got %h expected 00000000", rdata); end
    reset = 0;
    tick;
    cmp++; if ({awready, wready, arready} !== 3'b111) begin err++; $display("FAIL rst_release_ready: got %b expected 111", {awready, wready, arready}); end
  endtask
  task automatic test_basic;
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    wr(BASE + 32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
    cmp++; if (lat !== 0) begin err++; $display("FAIL basic_b_latency: got %0d expected 0", lat); end
    cmp++; if (resp !== 2'b00) begin err++; $display("FAIL basic_bresp: got %b expected 00", resp); end
    rd(BASE + 32'h10, d, resp, last, lat);
    cmp++; if (lat !== 0) begin err++; $display("FAIL basic_r_latency: got %0d expected 0", lat); end
    cmp++; if (d !== 32'hDEADBEEF) begin err++; $display("FAIL basic_rdata: got %h expected deadbeef", d); end
    cmp++; if ({resp, last} !== 3'b001) begin err++; $display("FAIL basic_rresp_rlast: got %b expected 001", {resp, last}); end
    rd(BASE + 32'h13, d, resp, last, lat);
    cmp++; if (d !== 32'hDEADBEEF) begin err++; $display("FAIL basic_unaligned: got %h expected deadbeef", d); end
    wr(BASE + 32'h10, 32'h0, 4'h0, resp, lat);
    cmp++; if (resp !== 2'b00) begin err++; $display("FAIL strb0_bresp: got %b expected 00", resp); end
    rd(BASE + 32'h10, d, resp, last, lat);
    cmp++; if (d !== 32'hDEADBEEF) begin err++; $display("FAIL strb0_rdata: got %h expected deadbeef", d); end
  endtask
  task automatic test_w_first;
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    wr(BASE + 32'h20, 32'hAAAAAAAA, 4'hF, resp, lat);
    wvalid = 1; wdata = 32'h11223344; wstrb = 4'b0101;
    tick;
    wvalid = 0;
    cmp++; if ({wready, awready, bvalid} !== 3'b010) begin err++; $display("FAIL wfirst_latched: got %b expected 010", {wready, awready, bvalid}); end
    tick; tick;
    cmp++; if ({wready, bvalid} !== 2'b00) begin err++; $display("FAIL wfirst_wait: got %b expected 00", {wready, bvalid}); end
    awvalid = 1; awaddr = BASE + 32'h20;
    tick;
    awvalid = 0;
    cmp++; if ({bvalid, bresp} !== 3'b100) begin err++; $display("FAIL wfirst_bvalid: got %b expected 100", {bvalid, bresp}); end
    bready = 1;
    tick;
    bready = 0;
    rd(BASE + 32'h20, d, resp, last, lat);
    cmp++; if (d !== 32'hAA22AA44) begin err++; $display("FAIL wfirst_rdata: got %h expected aa22aa44", d); end
  endtask
  task automatic test_out_of_range;
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    wr(BASE + 32'h3FC, 32'hCAFEF00D, 4'hF, resp, lat);
    wr(BASE, 32'h0BADC0DE, 4'hF, resp, lat);
    rd(BASE + 32'h400, d, resp, last, lat);
    cmp++; if ({d, resp} !== {32'h0, 2'b10}) begin err++; $display("FAIL oor_read: got %h/%b expected 00000000/10", d, resp); end
    wr(BASE + 32'h400, 32'h12345678, 4'hF, resp, lat);
    cmp++; if (resp !== 2'b10) begin err++; $display("FAIL oor_bresp: got %b expected 10", resp); end
    rd(BASE - 32'h4, d, resp, last, lat);
    cmp++; if ({d, resp} !== {32'h0, 2'b10}) begin err++; $display("FAIL below_base_read: got %h/%b expected 00000000/10", d, resp); end
    rd(BASE + 32'h3FC, d, resp, last, lat);
    cmp++; if ({d, resp} !== {32'hCAFEF00D, 2'b00}) begin err++; $display("FAIL last_word: got %h/%b expected cafef00d/00", d, resp); end
    rd(BASE, d, resp, last, lat);
    cmp++; if (d !== 32'h0BADC0DE) begin err++; $display("FAIL oor_no_alias: got %h expected 0badc0de", d); end
  endtask
  task automatic test_stall;
    awvalid = 1; awaddr = BASE + 32'h40; wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF;
    arvalid = 1; araddr = BASE + 32'h10;
    tick;
    awvalid = 0; wvalid = 0; araddr = BASE + 32'h40;
    for (int i = 0; i < 5; i++) begin
      cmp++; if ({bvalid, bresp, rvalid, rresp} !== 6'b100100) begin err++; $display("FAIL stall_valid[%0d]: got %b expected 100100", i, {bvalid, bresp, rvalid, rresp}); end
      cmp++; if (rdata !== 32'hDEADBEEF) begin err++; $display("FAIL stall_rdata[%0d]: got %h expected deadbeef", i, rdata); end
      cmp++; if ({awready, wready, arready} !== 3'b000) begin err++; $display("FAIL stall_ready[%0d]: got %b expected 000", i, {awready, wready, arready}); end
      tick;
    end
    rready = 1; bready = 1;
    tick;
    cmp++; if ({bvalid, rvalid, awready, arready} !== 4'b0011) begin err++; $display("FAIL stall_release: got %b expected 0011", {bvalid, rvalid, awready, arready}); end
    tick;
    arvalid = 0;
    cmp++; if ({rvalid, rdata} !== {1'b1, 32'h55AA55AA}) begin err++; $display("FAIL back_to_back_read: got %b/%h expected 1/55aa55aa", rvalid, rdata); end
    tick;
    cmp++; if (rvalid !== 1'b0) begin err++; $display("FAIL back_to_back_done: got %b expected 0", rvalid); end
    rready = 0; bready = 0;
  endtask
  task automatic test_same_edge;
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    wr(BASE + 32'h50, 32'h5, 4'hF, resp, lat);
    awvalid = 1; awaddr = BASE + 32'h50; wvalid = 1; wdata = 32'h0; wstrb = 4'hF;
    arvalid = 1; araddr = BASE + 32'h50;
    tick;
    awvalid = 0; wvalid = 0; arvalid = 0;
    cmp++; if ({bvalid, rvalid, rdata} !== {2'b11, 32'h5}) begin err++; $display("FAIL same_edge_old: got %b%b/%h expected 11/00000005", bvalid, rvalid, rdata); end
    bready = 1; rready = 1;
    tick;
    bready = 0; rready = 0;
    rd(BASE + 32'h50, d, resp, last, lat);
    cmp++; if (d !== 32'h0) begin err++; $display("FAIL same_edge_new: got %h expected 00000000", d); end
  endtask
  task automatic test_reset_abort;
    logic [1:0] resp; logic [31:0] d; logic last; int lat;
    wr(BASE + 32'h60, 32'h77777777, 4'hF, resp, lat);
    awvalid = 1; awaddr = BASE + 32'h60;
    tick;
    awvalid = 0; reset = 1;
    tick;
    cmp++; if ({awready, wready, arready, bvalid, rvalid, rlast, bresp, rresp} !== 10'b0) begin err++; $display("FAIL abort_rst_outputs: got %b expected 0000000000", {awready, wready, arready, bvalid, rvalid, rlast, bresp, rresp}); end
    cmp++; if (rdata !== 32'h0) begin err++; $display("FAIL abort_rst_rdata: got %h expected 00000000", rdata); end
    reset = 0;
    tick;
    wvalid = 1; wdata = 32'h0; wstrb = 4'hF;
    tick;
    wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      cmp++; if (bvalid !== 1'b0) begin err++; $display("FAIL abort_no_bvalid[%0d]: got %b expected 0", i, bvalid); end
      tick;
    end
    cmp++; if ({awready, wready} !== 2'b10) begin err++; $display("FAIL abort_aw_dropped: got %b expected 10", {awready, wready}); end
    rd(BASE + 32'h60, d, resp, last, lat);
    cmp++; if (d !== 32'h77777777) begin err++; $display("FAIL abort_mem_kept: got %h expected 77777777", d); end
    reset = 1;
    tick;
    reset = 0;
    tick;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_w_first;
    test_out_of_range;
    test_stall;
    test_same_edge;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
